// File: rtl/scope_decimator.sv
// Multi-channel stream decimator/averager for scope capture.
// Each window of cfg_dec+1 accepted beats, or fewer when sti_tlast ends it
// early, produces one output beat. The output is either the final sample of
// the window or the rounded, shifted and saturated window sum.
module scope_decimator #(
  parameter int unsigned CN  = 2,
  parameter int unsigned DWI = 14,
  parameter int unsigned DWO = 14,
  parameter int unsigned DCW = 17,
  parameter int unsigned DSW = 4
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              ctl_rst,
  input  logic              cfg_avg,
  input  logic [DCW-1:0]    cfg_dec,
  input  logic [DSW-1:0]    cfg_shr,
  input  logic              cfg_rnd,
  input  logic [CN*DWI-1:0] sti_tdata,
  input  logic              sti_tvalid,
  input  logic              sti_tlast,
  output logic              sti_tready,
  output logic [CN*DWO-1:0] sto_tdata,
  output logic              sto_tvalid,
  output logic              sto_tlast,
  input  logic              sto_tready
);

  // AW: accumulator width. EW: one extra bit so that adding the rounding
  // constant cannot overflow.
  localparam int unsigned AW = DCW + DWI;
  localparam int unsigned EW = AW + 1;

  logic [DCW-1:0]    cnt_q, cnt_d;
  logic [AW-1:0]     acc_q [CN];
  logic [AW-1:0]     acc_d [CN];
  logic              last_q, last_d;
  logic [CN*DWO-1:0] tdata_q, tdata_d;
  logic              tvalid_q, tvalid_d;
  logic              tlast_q, tlast_d;

  logic [AW-1:0]     smp [CN];
  logic [AW-1:0]     sum [CN];
  logic [EW-1:0]     ext [CN];
  logic [EW-1:0]     shf [CN];
  logic [EW-1:0]     rnd;
  logic [CN*DWO-1:0] res;
  logic              accept;
  logic              final_beat;
  logic              win_last;

  // Clamp a signed EW-bit value to the signed DWO-bit range.
  function automatic logic [DWO-1:0] sat(input logic [EW-1:0] v);
    logic [EW-DWO:0] top;
    top = v[EW-1:DWO-1];
    if ((&top) || (~|top)) return v[DWO-1:0];
    else if (v[EW-1])     return {1'b1, {(DWO-1){1'b0}}};
    else                  return {1'b0, {(DWO-1){1'b1}}};
  endfunction

  assign sti_tready = ~ctl_rst & (~tvalid_q | sto_tready);
  assign accept     = sti_tvalid & sti_tready;
  assign final_beat = (cnt_q == cfg_dec) | sti_tlast;
  assign win_last   = last_q | sti_tlast;

  assign sto_tdata  = tdata_q;
  assign sto_tvalid = tvalid_q;
  assign sto_tlast  = tlast_q;

  // Per-channel running sum including the current beat, and the result of
  // the selected mode.
  always_comb begin
    rnd = '0;
    res = '0;
    if (cfg_rnd && (cfg_shr != '0)) rnd = EW'(1) << (cfg_shr - DSW'(1));
    for (int k = 0; k < CN; k++) begin
      smp[k] = {{(AW-DWI){sti_tdata[k*DWI + DWI - 1]}}, sti_tdata[k*DWI +: DWI]};
      sum[k] = (cnt_q == '0) ? smp[k] : acc_q[k] + smp[k];
      ext[k] = {sum[k][AW-1], sum[k]} + rnd;
      shf[k] = $signed(ext[k]) >>> cfg_shr;
      res[k*DWO +: DWO] = cfg_avg ? sat(shf[k]) : sat({smp[k][AW-1], smp[k]});
    end
  end

  // Window counter, accumulators, sticky last and output register update.
  always_comb begin
    cnt_d    = cnt_q;
    last_d   = last_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    for (int k = 0; k < CN; k++) acc_d[k] = acc_q[k];
    if (ctl_rst) begin
      cnt_d    = '0;
      last_d   = 1'b0;
      tvalid_d = 1'b0;
      for (int k = 0; k < CN; k++) acc_d[k] = '0;
    end else begin
      if (tvalid_q && sto_tready) tvalid_d = 1'b0;
      if (accept) begin
        for (int k = 0; k < CN; k++) acc_d[k] = sum[k];
        if (final_beat) begin
          cnt_d    = '0;
          last_d   = 1'b0;
          tdata_d  = res;
          tvalid_d = 1'b1;
          tlast_d  = win_last;
        end else begin
          cnt_d  = cnt_q + DCW'(1);
          last_d = win_last;
        end
      end
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      cnt_q    <= '0;
      last_q   <= 1'b0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      for (int k = 0; k < CN; k++) acc_q[k] <= '0;
    end else begin
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      for (int k = 0; k < CN; k++) acc_q[k] <= acc_d[k];
    end
  end

endmodule

// File: doc/scope_decimator.md
SCOPE_DECIMATOR -- requirements
Module: scope_decimator

Interface
REQ-001 Parameter CN, default 2: number of parallel channels sharing one stream beat.
REQ-002 Parameter DWI, default 14: signed input sample width per channel.
REQ-003 Parameter DWO, default 14: signed output sample width per channel.
REQ-004 Parameter DCW, default 17: decimation counter width.
REQ-005 Parameter DSW, default 4: shift-amount width.
REQ-006 ACLK  in  1  single clock; all logic on its rising edge.
REQ-007 ARESET  in  1  asynchronous, active-high reset.
REQ-008 ctl_rst  in  1  synchronous clear of window state (counter, accumulators, sticky last, output valid).
REQ-009 cfg_avg  in  1  1 = averaging mode; 0 = decimation (pick) mode.
REQ-010 cfg_dec  in  DCW  window length minus one; window length N = cfg_dec+1.
REQ-011 cfg_shr  in  DSW  arithmetic right shift applied to the sum (averaging mode only).
REQ-012 cfg_rnd  in  1  1 = round half up before the shift; 0 = truncate.
REQ-013 sti_tdata  in  CN*DWI  input samples; channel k occupies bits [k*DWI +: DWI].
REQ-014 sti_tvalid / sti_tlast  in  1 each; sti_tready  out  1.
REQ-015 sto_tdata  out  CN*DWO  output samples, same channel packing as the input.
REQ-016 sto_tvalid / sto_tlast  out  1 each; sto_tready  in  1.

Function
REQ-017 Input beat accepted when sti_tvalid & sti_tready; sti_tready = ~ctl_rst & (~sto_tvalid | sto_tready).
REQ-018 Counter cnt counts accepted beats 0..cfg_dec; a beat is final when cnt==cfg_dec or sti_tlast==1; on a final beat cnt returns to 0, otherwise it increments.
REQ-019 Per-channel accumulator, signed width DCW+DWI: loaded with the sample on the first beat of a window (cnt==0), otherwise sample added; it never wraps for N <= 2^DCW.
REQ-020 Averaging result per channel = (sum + R) >>> cfg_shr, where sum includes the final beat and R = 2^(cfg_shr-1) if cfg_rnd & cfg_shr>0, else 0; the result is saturated to signed DWO bits.
REQ-021 Decimation result per channel = final-beat sample, sign-extended or saturated to DWO bits; cfg_shr and cfg_rnd are ignored.
REQ-022 On a final beat, sto_tdata is registered and sto_tvalid is set on the next clock edge (latency 1 cycle); non-final beats produce no output.
REQ-023 sto_tlast = OR of sti_tlast over the window; a TLAST-terminated partial window is emitted with the same formula and is not rescaled.
REQ-024 While sto_tvalid & ~sto_tready, sto_tdata and sto_tlast hold stable and no input is accepted; sto_tvalid clears on handshake unless a new final beat is accepted in the same cycle.
REQ-025 With cfg_dec=0 and sto_tready held 1, throughput is one output per clock.
REQ-026 ctl_rst has priority over any input beat in the same cycle: cnt, accumulators and sticky last clear to 0, sto_tvalid clears to 0, and a pending output is discarded.
REQ-027 Configuration changes are legal only while ctl_rst=1; behaviour with configuration changing mid-window is undefined.

Reset
REQ-028 ARESET=1 asynchronously forces cnt=0, accumulators=0, sticky last=0, sto_tvalid=0, sto_tlast=0 and sto_tdata=0; sti_tready evaluates to 1 after release (with ctl_rst=0).
REQ-029 The first accepted beat after ARESET or ctl_rst release starts a new window at cnt=0.

Verification
REQ-030 Decimation, cfg_dec=3, ch0 inputs 0..7, sto_tready=1 -> outputs 3 and 7, each sto_tvalid exactly one cycle after beats 4 and 8.
REQ-031 Averaging, cfg_dec=3, cfg_shr=2, ch0 inputs 1,2,3,4 -> output 3 with cfg_rnd=1 and 2 with cfg_rnd=0.
REQ-032 Saturation, cfg_avg=1, cfg_dec=3, cfg_shr=0, four beats of 8191 -> 8191; four beats of -8192 -> -8192 (DWO=14).
REQ-033 TLAST flush, cfg_avg=1, cfg_dec=7, cfg_shr=0, inputs 5,5,5 with TLAST on the third beat -> output 15 with sto_tlast=1; the next beat opens a fresh window.
REQ-034 Back-pressure, cfg_dec=0, sto_tready=0 for 5 cycles with continuous input -> sti_tready low after the first output, output held stable, no samples lost or reordered once sto_tready returns to 1.
REQ-035 ctl_rst pulse after 2 of 4 beats, then ARESET asserted mid-window -> no output emitted, and the next window sums only post-reset beats.
